// File: rtl/addernet_result_collector.sv
// addernet_result_collector
//   Sums NTILE partial results (each one kernel slice of sum|x-w|) per output
//   activation, negates and saturates the total to OW bits, and buffers the
//   result in a show-ahead FIFO with a valid/ready output. Also returns a
//   credit (o_in_ready) to the upstream feeder, which cannot be stalled once
//   an input has been issued.
// Ports:
//   CLK, RST      clock, asynchronous active-high reset
//   i_clear       abort the current tile sequence (FIFO untouched)
//   i_valid       i_result carries one partial sum this cycle
//   i_result      unsigned partial sum, RW bits
//   o_in_ready    credit: safe to issue a new core input this cycle
//   o_valid       FIFO head valid
//   o_data        FIFO head (two's complement), 0 when empty
//   i_ready       downstream accepts the head when o_valid && i_ready
//   o_overflow    sticky: a finished result was dropped on a full FIFO
module addernet_result_collector #(
   parameter int unsigned RW    = 16,
   parameter int unsigned NTILE = 4,
   parameter int unsigned OW    = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          i_clear,
   input  logic          i_valid,
   input  logic [RW-1:0] i_result,
   output logic          o_in_ready,
   output logic          o_valid,
   output logic [OW-1:0] o_data,
   input  logic          i_ready,
   output logic          o_overflow
);

   localparam int unsigned AW   = RW + $clog2(NTILE) + 1;
   localparam int unsigned TW   = (NTILE > 1) ? $clog2(NTILE) : 1;
   localparam int unsigned PW   = $clog2(DEPTH);
   localparam int unsigned CNTW = PW + 1;
   // Wide enough to hold both the sum and the 2^(OW-1) saturation limit
   localparam int unsigned CW   = ((AW > OW) ? AW : OW) + 1;

   typedef enum logic {
      ACC_IDLE,
      ACC_RUN
   } acc_state_e;

   acc_state_e        state_q, state_d;
   logic [TW-1:0]     tcnt_q, tcnt_d;
   logic [AW-1:0]     acc_q, acc_d;
   logic [AW-1:0]     sum_c;
   logic [CW-1:0]     sum_w_c;
   logic              last_c;
   logic              push_c;
   logic [OW-1:0]     push_val_c;

   logic [OW-1:0]     mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic              overflow_q;
   logic              pop_c, full_c, wr_c;

   // Tile accumulation FSM: next state, accumulator and completion push
   always_comb begin
      state_d = state_q;
      tcnt_d  = tcnt_q;
      acc_d   = acc_q;
      push_c  = 1'b0;
      sum_c   = acc_q + AW'(i_result);
      last_c  = (tcnt_q == TW'(NTILE - 1));
      if (i_clear) begin
         state_d = ACC_IDLE;
         tcnt_d  = '0;
         acc_d   = '0;
      end else if (i_valid) begin
         if (last_c) begin
            push_c  = 1'b1;
            state_d = ACC_IDLE;
            tcnt_d  = '0;
            acc_d   = '0;
         end else begin
            state_d = ACC_RUN;
            tcnt_d  = tcnt_q + TW'(1);
            acc_d   = sum_c;
         end
      end
   end

   // Negate the finished sum; clamp to the most negative OW-bit value
   always_comb begin
      sum_w_c = CW'(sum_c);
      if (sum_w_c > (CW'(1) << (OW - 1))) begin
         push_val_c = {1'b1, {(OW - 1){1'b0}}};
      end else begin
         push_val_c = OW'(CW'(0) - sum_w_c);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ACC_IDLE;
         tcnt_q  <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         acc_q   <= acc_d;
      end
   end

   // FIFO control: a full FIFO still accepts a push when the head pops together
   always_comb begin
      pop_c  = o_valid && i_ready;
      full_c = (cnt_q == CNTW'(DEPTH));
      wr_c   = push_c && (!full_c || pop_c);
      cnt_d  = cnt_q + CNTW'(wr_c) - CNTW'(pop_c);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (wr_c) begin
            mem_q[wr_ptr_q] <= push_val_c;
            wr_ptr_q        <= wr_ptr_q + PW'(1);
         end
         if (pop_c) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         cnt_q <= cnt_d;
         if (push_c && !wr_c) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Outputs decode registered state only; no path from i_result to o_data
   always_comb begin
      o_valid    = (cnt_q != '0);
      o_data     = o_valid ? mem_q[rd_ptr_q] : '0;
      // Two inputs may already be in the core pipeline plus the one issued now
      o_in_ready = ((CNTW'(DEPTH) - cnt_q) >= CNTW'(3));
      o_overflow = overflow_q;
   end

endmodule

// File: tb/tb_addernet_result_collector.sv
module tb_addernet_result_collector;

   localparam int RW    = 16;
   localparam int NTILE = 4;
   localparam int OW    = 16;
   localparam int DEPTH = 4;

   logic          CLK;
   logic          RST;
   logic          i_clear;
   logic          i_valid;
   logic [RW-1:0] i_result;
   logic          o_in_ready;
   logic          o_valid;
   logic [OW-1:0] o_data;
   logic          i_ready;
   logic          o_overflow;

   addernet_result_collector #(
      .RW(RW), .NTILE(NTILE), .OW(OW), .DEPTH(DEPTH)
   ) dut (
      .CLK(CLK), .RST(RST), .i_clear(i_clear), .i_valid(i_valid),
      .i_result(i_result), .o_in_ready(o_in_ready), .o_valid(o_valid),
      .o_data(o_data), .i_ready(i_ready), .o_overflow(o_overflow)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   // Reference model: plain running sum per activation, FIFO as an occupancy
   int m_sum = 0;
   int m_n   = 0;
   int occ   = 0;
   int ovf   = 0;
   int exp_q[$];
   int got_q[$];

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         m_sum = 0; m_n = 0; occ = 0; ovf = 0;
         exp_q.delete();
      end else begin
         bit pop, push;
         int val;
         pop  = (occ > 0) && i_ready;
         push = 1'b0;
         val  = 0;
         if (i_clear) begin
            m_sum = 0; m_n = 0;
         end else if (i_valid) begin
            m_sum += int'(i_result);
            m_n++;
            if (m_n == NTILE) begin
               push  = 1'b1;
               val   = (m_sum > 32768) ? -32768 : -m_sum;
               m_sum = 0; m_n = 0;
            end
         end
         if (push) begin
            if (occ < DEPTH || pop) begin
               exp_q.push_back(val);
               occ++;
            end else begin
               ovf = 1;
            end
         end
         if (pop) occ--;
      end
   end

   // Monitor: compare the presented head against the scoreboard queue
   always @(negedge CLK) begin
      if (!RST) begin
         int hd;
         chk("o_valid", int'(o_valid), int'(occ > 0));
         chk("o_in_ready", int'(o_in_ready), int'((DEPTH - occ) >= 3));
         chk("o_overflow", int'(o_overflow), ovf);
         if (o_valid) begin
            hd = (exp_q.size() > 0) ? exp_q[0] : 99999;
            chk("o_data_head", int'($signed(o_data)), hd);
            if (i_ready) begin
               got_q.push_back(int'($signed(o_data)));
               if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
         end else begin
            chk("o_data_empty", int'(o_data), 0);
         end
      end
   end

   task automatic cyc(input logic v, input int r, input logic c, input logic rdy);
      @(posedge CLK);
      #1;
      i_valid  = v;
      i_result = RW'(r);
      i_clear  = c;
      i_ready  = rdy;
   endtask

   task automatic idle(input int n, input logic rdy);
      repeat (n) cyc(1'b0, 0, 1'b0, rdy);
   endtask

   // One activation: value v in the first slice, zeros in the rest
   task automatic tile(input int v, input logic rdy);
      cyc(1'b1, v, 1'b0, rdy);
      repeat (NTILE - 1) cyc(1'b1, 0, 1'b0, rdy);
   endtask

   task automatic expect_got(input string nm, input int exp);
      if (got_q.size() == 0) chk({nm, "_present"}, 0, exp);
      else chk(nm, got_q.pop_front(), exp);
   endtask

   task automatic chk_reset_outs(input string nm);
      chk({nm, "_valid"}, int'(o_valid), 0);
      chk({nm, "_data"}, int'(o_data), 0);
      chk({nm, "_in_ready"}, int'(o_in_ready), 1);
      chk({nm, "_overflow"}, int'(o_overflow), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      RST = 1'b1; i_clear = 1'b0; i_valid = 1'b0; i_result = '0; i_ready = 1'b1;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      chk_reset_outs("reset");

      // Basic 4-slice sum
      cyc(1'b1, 10, 1'b0, 1'b1); cyc(1'b1, 20, 1'b0, 1'b1);
      cyc(1'b1, 30, 1'b0, 1'b1); cyc(1'b1, 40, 1'b0, 1'b1);
      idle(8, 1'b1);
      expect_got("basic_sum", -100);
      chk("basic_single_output", got_q.size(), 0);

      // Saturation boundaries
      repeat (4) cyc(1'b1, 16000, 1'b0, 1'b1);
      repeat (4) cyc(1'b1, 8192, 1'b0, 1'b1);
      repeat (4) cyc(1'b1, 0, 1'b0, 1'b1);
      idle(6, 1'b1);
      expect_got("sat_64000", -32768);
      expect_got("sat_32768", -32768);
      expect_got("sum_zero", 0);

      // Backpressure: fifth result dropped
      for (int v = 1; v <= 5; v++) tile(v, 1'b0);
      idle(3, 1'b0);
      chk("bp_overflow", int'(o_overflow), 1);
      chk("bp_in_ready", int'(o_in_ready), 0);
      idle(10, 1'b1);
      for (int v = 1; v <= 4; v++) expect_got("bp_order", -v);
      chk("bp_no_extra", got_q.size(), 0);

      // Asynchronous reset mid-tile with a non-empty FIFO
      tile(3, 1'b0);
      cyc(1'b1, 5, 1'b0, 1'b0); cyc(1'b1, 5, 1'b0, 1'b0);
      @(posedge CLK);
      #1 i_valid = 1'b0;
      #1 RST = 1'b1;
      #1 chk_reset_outs("async_reset");
      #1 RST = 1'b0;
      repeat (4) cyc(1'b1, 1, 1'b0, 1'b1);
      idle(6, 1'b1);
      expect_got("after_reset", -4);
      chk("after_reset_only", got_q.size(), 0);

      // Full FIFO with simultaneous push and pop
      for (int v = 1; v <= 4; v++) tile(v, 1'b0);
      cyc(1'b1, 7, 1'b0, 1'b0); cyc(1'b1, 0, 1'b0, 1'b0);
      cyc(1'b1, 0, 1'b0, 1'b0); cyc(1'b1, 0, 1'b0, 1'b1);
      idle(10, 1'b1);
      expect_got("full_pp0", -1);
      expect_got("full_pp1", -2);
      expect_got("full_pp2", -3);
      expect_got("full_pp3", -4);
      expect_got("full_pp4", -7);
      chk("full_pp_overflow", int'(o_overflow), 0);

      // Clear discards the beat it accompanies and the partial sum
      cyc(1'b1, 5, 1'b0, 1'b1); cyc(1'b1, 5, 1'b0, 1'b1);
      cyc(1'b1, 5, 1'b1, 1'b1);
      repeat (4) cyc(1'b1, 2, 1'b0, 1'b1);
      idle(6, 1'b1);
      expect_got("after_clear", -8);
      chk("after_clear_only", got_q.size(), 0);

      // Randomised traffic against the model
      for (int k = 0; k < 400; k++) begin
         int r;
         r = ($urandom % 2 == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 200));
         cyc(($urandom % 4) != 0, r, ($urandom % 25) == 0, ($urandom % 3) != 0);
      end
      idle(12, 1'b1);
      chk("random_drained", exp_q.size(), 0);
      got_q.delete();

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
